// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: one outstanding imem request feeding a DEPTH-entry prefetch queue.
// Optional performance counters (fetch_cnt, flush_cnt) are built when FETCH_PERF_EN is defined.
module fetch_queue_stage #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            StallD,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            ValidD,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
`ifdef FETCH_PERF_EN
   output logic [31:0]     fetch_cnt,
   output logic [31:0]     flush_cnt,
`endif
   output logic [XLEN-1:0] PCPlus4D
);

   localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [XLEN-1:0] FOUR    = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_M = ~XLEN'(3);

   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  req_pc;
   logic             outstanding;
   logic             drop;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic [XLEN-1:0]  instr_q [DEPTH];
   logic [XLEN-1:0]  pc_q    [DEPTH];
   logic [XLEN-1:0]  pc4_q   [DEPTH];

   logic grant;
   logic push;
   logic pop;

   assign ValidD    = (count != '0);
   assign imem_addr = fetch_pc;
   assign imem_req  = !rst && start && !PCSrcE && !outstanding && (count < DEPTH_C);
   assign grant     = imem_req && imem_gnt;
   // A redirect kills both ends of the queue in the same cycle it empties it.
   assign push      = imem_rvalid && outstanding && !drop && !PCSrcE;
   assign pop       = ValidD && !StallD && !PCSrcE;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         req_pc      <= '0;
         outstanding <= 1'b0;
         drop        <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else if (PCSrcE) begin
         fetch_pc <= PCTargetE & ALIGN_M;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         if (outstanding) begin
            if (imem_rvalid) begin
               outstanding <= 1'b0;
               drop        <= 1'b0;
            end else begin
               drop <= 1'b1;
            end
         end
      end else begin
         if (grant) begin
            outstanding <= 1'b1;
            req_pc      <= fetch_pc;
            fetch_pc    <= fetch_pc + FOUR;
         end else if (imem_rvalid && outstanding) begin
            outstanding <= 1'b0;
            drop        <= 1'b0;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: queue storage has no reset; ValidD gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr] <= imem_rdata;
         pc_q[wr_ptr]    <= req_pc;
         pc4_q[wr_ptr]   <= req_pc + FOUR;
      end
   end

   // NOTE: defaults first keep this block free of inferred latches.
   always_comb begin
      InstrD   = '0;
      PCD      = '0;
      PCPlus4D = '0;
      if (ValidD) begin
         InstrD   = instr_q[rd_ptr];
         PCD      = pc_q[rd_ptr];
         PCPlus4D = pc4_q[rd_ptr];
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (push)   fetch_cnt <= fetch_cnt + 32'd1;
         if (PCSrcE) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed testbench for fetch_queue_stage (XLEN=32, DEPTH=4, RESET_PC=0).
// A one-cycle-latency imem responder returns instruction = address + INSTR_OFS.
module tb_fetch_queue_stage;

   localparam logic [31:0] INSTR_OFS = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst, start, pcsrc, stall, gnt, rvalid;
   logic [31:0] target, rdata;
   logic        imem_req, ValidD;
   logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt, flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic        pend;
   logic [31:0] pend_addr;
   logic [31:0] exp_addr;
   logic [31:0] exp_pop;

   fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .start(start), .PCSrcE(pcsrc), .PCTargetE(target),
      .StallD(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(gnt),
      .imem_rvalid(rvalid), .imem_rdata(rdata), .ValidD(ValidD), .InstrD(InstrD),
      .PCD(PCD),
`ifdef FETCH_PERF_EN
      .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt),
`endif
      .PCPlus4D(PCPlus4D)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b1; pcsrc = 1'b0; stall = 1'b0; gnt = 1'b1;
      rvalid = 1'b0; target = '0; rdata = '0;
      tick();
      rst = 1'b0;
      pend = 1'b0; pend_addr = '0; exp_addr = '0; exp_pop = '0;
   endtask

   // Runs n cycles with the responder; checks every grant address and the head entry in order.
   task automatic run_cycles(input int n);
      logic        g;
      logic [31:0] ga;
      for (int i = 0; i < n; i++) begin
         rvalid = pend;
         rdata  = pend ? pend_addr + INSTR_OFS : 32'h0;
         #1;
         if (ValidD) begin
            n_checks++;
            if (PCD !== exp_pop || PCPlus4D !== exp_pop + 32'd4 || InstrD !== exp_pop + INSTR_OFS) begin
               n_fail++;
               $display("FAIL head_entry: PCD=%h PCPlus4D=%h InstrD=%h, expected PCD=%h", PCD, PCPlus4D, InstrD, exp_pop);
            end
            if (!stall) exp_pop = exp_pop + 32'd4;
         end
         g  = imem_req && gnt;
         ga = imem_addr;
         if (g) begin
            n_checks++;
            if (imem_addr !== exp_addr) begin
               n_fail++;
               $display("FAIL grant_addr: imem_addr=%h expected %h", imem_addr, exp_addr);
            end
            exp_addr = exp_addr + 32'd4;
         end
         tick();
         pend = g; pend_addr = ga;
      end
      rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; pcsrc = 1'b0; stall = 1'b0; gnt = 1'b1;
      rvalid = 1'b1; rdata = 32'hFFFF_FFFF; target = 32'h40;
      tick(); tick();
      n_checks++;
      if (imem_req !== 1'b0 || ValidD !== 1'b0 || PCD !== 32'h0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: req=%b ValidD=%b PCD=%h InstrD=%h PCPlus4D=%h, expected all 0", imem_req, ValidD, PCD, InstrD, PCPlus4D);
      end
      rst = 1'b0; rvalid = 1'b0; #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_first_req: req=%b addr=%h, expected 1/00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_stream();
      do_reset();
      run_cycles(12);
      n_checks++;
      if (exp_pop !== 32'h14 || exp_addr !== 32'h18) begin
         n_fail++;
         $display("FAIL stream_progress: next pop %h next addr %h, expected 00000014/00000018", exp_pop, exp_addr);
      end
   endtask

   task automatic test_stall_full();
      do_reset();
      stall = 1'b1;
      run_cycles(12);
      n_checks++;
      if (imem_req !== 1'b0 || ValidD !== 1'b1 || PCD !== 32'h0) begin
         n_fail++;
         $display("FAIL stall_full: req=%b ValidD=%b PCD=%h, expected 0/1/00000000", imem_req, ValidD, PCD);
      end
      stall = 1'b0;
      run_cycles(16);
      n_checks++;
      if (exp_pop !== 32'h2C) begin
         n_fail++;
         $display("FAIL stall_release: next pop %h, expected 0000002c", exp_pop);
      end
   endtask

   task automatic test_redirect_outstanding();
      do_reset();
      run_cycles(1);
      pcsrc = 1'b1; target = 32'h0000_0103; #1;
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_req_block: req=%b expected 0", imem_req);
      end
      tick();
      pcsrc = 1'b0; #1;
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_wait_stale: req=%b expected 0", imem_req);
      end
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      rvalid = 1'b0; pend = 1'b0; #1;
      n_checks++;
      if (ValidD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
         n_fail++;
         $display("FAIL redirect_stale_drop: ValidD=%b req=%b addr=%h, expected 0/1/00000100", ValidD, imem_req, imem_addr);
      end
      exp_addr = 32'h100; exp_pop = 32'h100;
      run_cycles(6);
      n_checks++;
      if (exp_pop !== 32'h108) begin
         n_fail++;
         $display("FAIL redirect_resume: next pop %h, expected 00000108", exp_pop);
      end
   endtask

   task automatic test_redirect_coincident();
      do_reset();
      stall = 1'b1;
      run_cycles(3);
      rvalid = pend; rdata = pend_addr + INSTR_OFS;
      stall = 1'b0; pcsrc = 1'b1; target = 32'h200; #1;
      n_checks++;
      if (ValidD !== 1'b1 || rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL coincide_setup: ValidD=%b rvalid=%b, expected 1/1", ValidD, rvalid);
      end
      tick();
      pcsrc = 1'b0; rvalid = 1'b0; pend = 1'b0; gnt = 1'b0; #1;
      n_checks++;
      if (ValidD !== 1'b0 || PCD !== 32'h0 || InstrD !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL coincide_flush: ValidD=%b PCD=%h InstrD=%h req=%b addr=%h, expected 0/0/0/1/00000200", ValidD, PCD, InstrD, imem_req, imem_addr);
      end
      tick();
      n_checks++;
      if (ValidD !== 1'b0) begin
         n_fail++;
         $display("FAIL coincide_no_late_push: ValidD=%b expected 0", ValidD);
      end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      start = 1'b0; pcsrc = 1'b1; target = 32'hFFFF_FFFF;
      tick();
      pcsrc = 1'b0; start = 1'b1; #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL wrap_align: req=%b addr=%h, expected 1/fffffffc", imem_req, imem_addr);
      end
      exp_addr = 32'hFFFF_FFFC; exp_pop = 32'hFFFF_FFFC;
      run_cycles(6);
      n_checks++;
      if (exp_pop !== 32'h4 || exp_addr !== 32'h8) begin
         n_fail++;
         $display("FAIL wrap_progress: next pop %h next addr %h, expected 00000004/00000008", exp_pop, exp_addr);
      end
   endtask

   task automatic test_start_low();
      do_reset();
      run_cycles(1);
      start = 1'b0; rvalid = 1'b1; rdata = INSTR_OFS; #1;
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL start_low_req: req=%b expected 0", imem_req);
      end
      tick();
      rvalid = 1'b0; pend = 1'b0; #1;
      n_checks++;
      if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== INSTR_OFS || imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL start_low_push: ValidD=%b PCD=%h InstrD=%h req=%b, expected 1/0/10000000/0", ValidD, PCD, InstrD, imem_req);
      end
      tick();
      n_checks++;
      if (ValidD !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL start_low_drain: ValidD=%b req=%b, expected 0/0", ValidD, imem_req);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      stall = 1'b1;
      run_cycles(7);
      n_checks++;
      if (ValidD !== 1'b1 || pend !== 1'b1 || PCD !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_setup: ValidD=%b pend=%b PCD=%h, expected 1/1/00000000", ValidD, pend, PCD);
      end
      rst = 1'b1; #1;
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_req: req=%b expected 0", imem_req);
      end
      tick();
      n_checks++;
      if (ValidD !== 1'b0 || PCD !== 32'h0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_state: ValidD=%b PCD=%h InstrD=%h PCPlus4D=%h, expected all 0", ValidD, PCD, InstrD, PCPlus4D);
      end
`ifdef FETCH_PERF_EN
      n_checks++;
      if (fetch_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_perf: fetch_cnt=%0d flush_cnt=%0d, expected 0/0", fetch_cnt, flush_cnt);
      end
`endif
      rst = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_0000; #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_restart: req=%b addr=%h, expected 1/00000000", imem_req, imem_addr);
      end
      tick();
      rvalid = 1'b0; #1;
      n_checks++;
      if (ValidD !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_late_rvalid: ValidD=%b expected 0", ValidD);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_full();
      test_redirect_outstanding();
      test_redirect_coincident();
      test_pc_wrap();
      test_start_low();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
